ras_ckpt: RTL

Parametrised return-address stack for the frontend branch predictor. It generalises the fixed-depth RAS to any depth, reports overflow and underflow, and adds single-level checkpoint/restore. On a mispredict, the stack rolls back to its state at the checkpointed branch. Sits beside the BTB/BHT in the frontend: pushes on calls, pops on returns, and restores on a controller flush-with-recovery.

---
 rtl/ras_ckpt.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ras_ckpt.sv
// ras_ckpt -- return-address stack with single-level checkpoint/restore.
//
// Circular stack of DEPTH return addresses for the frontend predictor.
// Calls push, returns pop, and a mispredict recovery rolls the stack back
// to the state captured at the checkpointed branch. When the stack is full,
// a push overwrites the oldest entry and an overflow pulse is raised. A pop
// on an empty stack raises an underflow pulse.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      discard stack and checkpoint (highest priority)
//   push_i       push data_i
//   pop_i        pop top of stack
//   data_i       return address to push
//   ckpt_i       capture checkpoint of pre-update state
//   restore_i    roll back to checkpoint
//   data_o       top-of-stack entry (valid or not)
//   valid_o      stack non-empty
//   count_o      live entries, 0..DEPTH
//   overflow_o   one-cycle pulse: oldest entry overwritten
//   underflow_o  one-cycle pulse: pop while empty
module ras_ckpt #(
  parameter  int DEPTH = 4,
  parameter  int VLEN  = 32,
  localparam int CntW  = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] data_i,
  input  logic            ckpt_i,
  input  logic            restore_i,
  output logic [VLEN-1:0] data_o,
  output logic            valid_o,
  output logic [CntW-1:0] count_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  localparam int PtrW = $clog2(DEPTH);

  logic [VLEN-1:0] r_entry [DEPTH];
  logic [PtrW-1:0] r_tos;
  logic [CntW-1:0] r_count;
  logic [PtrW-1:0] r_ck_tos;
  logic [CntW-1:0] r_ck_count;
  logic [VLEN-1:0] r_ck_top;
  logic            r_ck_valid;
  logic            r_overflow;
  logic            r_underflow;

  logic [PtrW-1:0] w_tos_nxt;
  logic [CntW-1:0] w_count_nxt;
  logic            w_wr_en;
  logic [PtrW-1:0] w_wr_idx;
  logic [VLEN-1:0] w_wr_data;
  logic            w_ovf_nxt;
  logic            w_udf_nxt;
  logic            w_ck_cap;
  logic            w_ck_clr;
  logic [PtrW-1:0] w_tos_inc;
  logic [PtrW-1:0] w_tos_dec;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [PtrW-1:0] f_dec(input logic [PtrW-1:0] p);
    return (p == '0) ? PtrW'(DEPTH - 1) : p - PtrW'(1);
  endfunction

  assign w_tos_inc = f_inc(r_tos);
  assign w_tos_dec = f_dec(r_tos);

  always_comb begin
    w_tos_nxt   = r_tos;
    w_count_nxt = r_count;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_tos;
    w_wr_data   = data_i;
    w_ovf_nxt   = 1'b0;
    w_udf_nxt   = 1'b0;
    w_ck_cap    = 1'b0;
    w_ck_clr    = 1'b0;

    if (flush_i) begin
      w_tos_nxt   = '0;
      w_count_nxt = '0;
      w_ck_clr    = 1'b1;
    end else if (restore_i) begin
      if (r_ck_valid) begin
        // Only the checkpointed top entry can have been overwritten by
        // speculative pushes before the next pop below it, so it alone is
        // restored.
        w_tos_nxt   = r_ck_tos;
        w_count_nxt = r_ck_count;
        w_wr_en     = 1'b1;
        w_wr_idx    = r_ck_tos;
        w_wr_data   = r_ck_top;
      end else begin
        w_count_nxt = '0;
      end
    end else begin
      w_ck_cap = ckpt_i;
      if (push_i && pop_i) begin
        // Return-then-call: replace the top in place.
        w_wr_en     = 1'b1;
        w_wr_idx    = r_tos;
        w_count_nxt = (r_count == '0) ? CntW'(1) : r_count;
      end else if (push_i) begin
        w_tos_nxt = w_tos_inc;
        w_wr_en   = 1'b1;
        w_wr_idx  = w_tos_inc;
        if (r_count == CntW'(DEPTH)) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + CntW'(1);
        end
      end else if (pop_i) begin
        if (r_count != '0) begin
          w_tos_nxt   = w_tos_dec;
          w_count_nxt = r_count - CntW'(1);
        end else begin
          w_udf_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
      r_tos       <= '0;
      r_count     <= '0;
      r_ck_tos    <= '0;
      r_ck_count  <= '0;
      r_ck_top    <= '0;
      r_ck_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_tos       <= w_tos_nxt;
      r_count     <= w_count_nxt;
      r_overflow  <= w_ovf_nxt;
      r_underflow <= w_udf_nxt;
      if (w_wr_en) begin
        r_entry[w_wr_idx] <= w_wr_data;
      end
      if (w_ck_clr) begin
        r_ck_valid <= 1'b0;
      end else if (w_ck_cap) begin
        r_ck_tos   <= r_tos;
        r_ck_count <= r_count;
        r_ck_top   <= r_entry[r_tos];
        r_ck_valid <= 1'b1;
      end
    end
  end

  assign data_o      = r_entry[r_tos];
  assign valid_o     = (r_count != '0);
  assign count_o     = r_count;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule
